// File: rtl/config_read_arbiter.sv
// config_read_arbiter: shares one config read slave between NUM_MASTERS
// requesters. Round-robin grant, a single outstanding transaction, and the
// response is routed back to the requester that issued it. A response timeout
// answers the requester with an error. Any late slave response that follows a
// timeout is swallowed, and no new request is forwarded until that happens.
// ADDR_BITS/DATA_BITS default to the usual 32-bit AXI-Lite config widths.
module config_read_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int ADDR_BITS      = 32,
  parameter int DATA_BITS      = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_MASTERS*ADDR_BITS-1:0] m_read_addr,
  input  logic [NUM_MASTERS-1:0]         m_read_valid,
  output logic [NUM_MASTERS-1:0]         m_read_ready,
  output logic [NUM_MASTERS*DATA_BITS-1:0] m_resp_data,
  output logic [NUM_MASTERS-1:0]         m_resp_error,
  output logic [NUM_MASTERS-1:0]         m_resp_valid,
  input  logic [NUM_MASTERS-1:0]         m_resp_ready,
  output logic [ADDR_BITS-1:0]           s_read_addr,
  output logic                           s_read_valid,
  input  logic                           s_read_ready,
  input  logic [DATA_BITS-1:0]           s_resp_data,
  input  logic                           s_resp_error,
  input  logic                           s_resp_valid,
  output logic                           s_resp_ready,
  output logic                           busy,
  output logic [IW-1:0]                  grant_idx
);

  // Timer is wide enough to hold TIMEOUT_CYCLES; it saturates at all-ones.
  localparam int TW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : TW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_MASTERS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FWD  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RET  = 2'd3;

  logic [1:0]           r_state;
  logic [IW-1:0]        r_rr_ptr;
  logic [IW-1:0]        r_grant_idx;
  logic [ADDR_BITS-1:0] r_addr;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_err;
  logic                 r_drop_pending;
  logic [TW-1:0]        r_timer;

  logic                 w_found;
  logic [IW-1:0]        w_winner;
  logic [IW-1:0]        w_cand;
  logic [IW-1:0]        w_next_ptr;

  // Round-robin winner: first valid requester scanning upward from r_rr_ptr.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    w_found  = 1'b0;
    w_winner = '0;
    w_cand   = r_rr_ptr;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (!w_found && m_read_valid[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end
      w_cand = (w_cand == LAST_IDX) ? '0 : w_cand + 1'b1;
    end
  end

  assign w_next_ptr = (r_grant_idx == LAST_IDX) ? '0 : r_grant_idx + 1'b1;

  // Handshake outputs decoded from the current state.
  always_comb begin
    m_read_ready = '0;
    m_resp_valid = '0;
    m_resp_data  = '0;
    m_resp_error = '0;
    s_read_valid = 1'b0;
    s_read_addr  = '0;
    s_resp_ready = 1'b0;
    case (r_state)
      S_IDLE: if (!rst && w_found) m_read_ready[w_winner] = 1'b1;
      S_FWD: begin
        s_read_addr  = r_addr;
        s_read_valid = !r_drop_pending;
      end
      S_WAIT: s_resp_ready = 1'b1;
      S_RET: begin
        m_resp_valid[r_grant_idx] = 1'b1;
        m_resp_error[r_grant_idx] = r_err;
        m_resp_data[int'(r_grant_idx)*DATA_BITS +: DATA_BITS] = r_data;
      end
      default: ;
    endcase
    // A late response after a timeout is accepted and thrown away.
    if (r_drop_pending) s_resp_ready = 1'b1;
  end

  assign busy      = (r_state != S_IDLE) || r_drop_pending;
  assign grant_idx = r_grant_idx;

  // Transaction state machine, timeout timer and late-response drop flag.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      r_state        <= S_IDLE;
      r_rr_ptr       <= '0;
      r_grant_idx    <= '0;
      r_addr         <= '0;
      r_data         <= '0;
      r_err          <= 1'b0;
      r_drop_pending <= 1'b0;
      r_timer        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_addr      <= m_read_addr[int'(w_winner)*ADDR_BITS +: ADDR_BITS];
            r_grant_idx <= w_winner;
            r_state     <= S_FWD;
          end
        end
        S_FWD: begin
          if (s_read_valid && s_read_ready) begin
            r_timer <= '0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_timer != '1) r_timer <= r_timer + 1'b1;
          if (s_resp_valid) begin
            r_data  <= s_resp_data;
            r_err   <= s_resp_error;
            r_state <= S_RET;
          end else if (TIMEOUT_CYCLES != 0 && r_timer == TIMER_LAST) begin
            r_data         <= '0;
            r_err          <= 1'b1;
            r_drop_pending <= 1'b1;
            r_state        <= S_RET;
          end
        end
        S_RET: begin
          if (m_resp_ready[r_grant_idx]) begin
            r_rr_ptr <= w_next_ptr;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (r_drop_pending && s_resp_valid && r_state != S_WAIT)
        r_drop_pending <= 1'b0;
    end
  end

endmodule

// File: doc/config_read_arbiter.md
Name: config_read_arbiter

Overview:
- Shares one config read slave (read-request/response handshake pair) between NUM_MASTERS requesters, e.g. host-side register readback and on-chip debug/status pollers.
- Round-robin arbitration with exactly one outstanding transaction.
- Routes each response back to the requester that issued it.
- Response timeout: a hung slave answers the requester with an error instead of deadlocking the config path.

Parameters:
- NUM_MASTERS, 4, number of requesters (>=2).
- ADDR_BITS, AXI_ADDR_BITS, config address width.
- DATA_BITS, AXIL_DATA_BITS, config data width.
- TIMEOUT_CYCLES, 1024, cycles in WAIT_RESP before an error response is synthesised; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- m_read_addr  in  NUM_MASTERS*ADDR_BITS  per-requester address; slice i = master i.
- m_read_valid  in  NUM_MASTERS  per-requester request valid.
- m_read_ready  out  NUM_MASTERS  per-requester request ready.
- m_resp_data  out  NUM_MASTERS*DATA_BITS  per-requester response data.
- m_resp_error  out  NUM_MASTERS  per-requester response error.
- m_resp_valid  out  NUM_MASTERS  per-requester response valid.
- m_resp_ready  in  NUM_MASTERS  per-requester response ready.
- s_read_addr  out  ADDR_BITS  address to the shared slave.
- s_read_valid  out  1  request valid to the slave.
- s_read_ready  in  1  slave request ready.
- s_resp_data  in  DATA_BITS  slave response data.
- s_resp_error  in  1  slave response error.
- s_resp_valid  in  1  slave response valid.
- s_resp_ready  out  1  response ready to the slave.
- busy  out  1  high whenever state != IDLE or drop_pending.
- grant_idx  out  $clog2(NUM_MASTERS)  index of the current/last granted master.

Behaviour:
- Reset (rst high at a clk edge): state=IDLE; rr_ptr=0; grant_idx=0; drop_pending=0; timer=0.
  - All outputs 0: m_read_ready, m_resp_valid, m_resp_*, s_read_valid, s_read_addr, s_resp_ready.
  - Reset mid-operation abandons the transaction; no response is issued to anyone.
- Registered state machine: IDLE, FWD, WAIT_RESP, RET.
- IDLE:
  - Winner = first i with m_read_valid[i], scanning rr_ptr, rr_ptr+1, ... modulo NUM_MASTERS.
  - m_read_ready[winner]=1 combinationally; all other readies 0; no ready when no valid.
  - On handshake: latch addr_q and grant_idx=winner, go to FWD.
- FWD:
  - s_read_valid=1 and s_read_addr=addr_q, stable until s_read_ready.
  - While drop_pending=1, s_read_valid is held 0.
  - On s_read_valid&s_read_ready: timer=0, go to WAIT_RESP.
- WAIT_RESP:
  - s_resp_ready=1; timer increments each cycle.
  - On s_resp_valid: latch data_q/err_q from the slave, go to RET.
  - If TIMEOUT_CYCLES!=0 and timer reaches TIMEOUT_CYCLES-1 with no s_resp_valid: data_q=0, err_q=1, drop_pending=1, go to RET.
  - If s_resp_valid arrives in the same cycle as the timeout, the real response wins; no drop.
- RET:
  - m_resp_valid[grant_idx]=1 with data/error from data_q/err_q, stable until accepted.
  - Other masters' m_resp_valid stay 0; their m_resp_data/error are 0.
  - On m_resp_ready[grant_idx]: rr_ptr=(grant_idx+1) mod NUM_MASTERS, go to IDLE.
- drop_pending:
  - While set outside WAIT_RESP, s_resp_ready=1.
  - Any s_resp_valid is consumed and discarded; this clears the flag.
- Latency: master handshake at T0 -> s_read_valid at T1. With the slave ready at T1 and responding at T2, m_resp_valid is at T3.
- Throughput: at most one transaction per 4 cycles; a new grant occurs only from IDLE.
- Stray s_resp_valid in IDLE/FWD with no drop_pending: s_resp_ready=0; not consumed.
- Masters may deassert m_read_valid before grant with no effect.
- Width rules:
  - rr_ptr and grant_idx wrap modulo NUM_MASTERS (non-power-of-two supported).
  - The timer is $clog2(TIMEOUT_CYCLES+1) bits and saturates.

Test Plan:
- Single request: master 2 requests addr 0x40, slave ready at once, returns 0xDEADBEEF one cycle later -> m_resp_valid[2] at T3 with data 0xDEADBEEF, error 0, then busy=0.
- Round-robin: all 4 masters hold valid continuously -> grants in order 0,1,2,3,0. Each master gets exactly one response per rotation; no starvation over 40 transactions.
- Backpressure: slave holds s_read_ready=0 for 5 cycles, master 1 holds m_resp_ready=0 for 3 cycles -> s_read_addr and m_resp_data stay stable throughout; no second grant meanwhile.
- Timeout: TIMEOUT_CYCLES=8, slave never responds -> m_resp_valid for the requester with error=1, data=0, 8 cycles after the slave request handshake.
  - Late slave response 0x1234 then arrives -> it is consumed silently.
  - The next request is forwarded only after that consumption.
- Slave error: slave returns s_resp_error=1 with data 0x5 -> the requester sees error=1, data 0x5.
- Reset mid-WAIT_RESP: assert rst for 1 cycle -> all outputs 0, state IDLE, rr_ptr=0. A subsequent request from master 3 completes normally.
